ebus_master_seq: RTL and testbench

EBOX-side EBUS transaction sequencer. Takes one I/O request at a time from the EBOX microcode path: controller select, function and write data. Runs the EBUS demand/ack/xfer handshake with devices, captures read data and returns a single response with status. Its data output feeds the EBUS mux as one `tEBUSdriver` slot; cs/func/demand feed the shared `iEBUS` lines.

---
 rtl/ebus_master_seq.sv | 208 ++++++++++++++++++++
 tb/tb_ebus_master_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_master_seq.sv
// ebus_master_seq: EBOX-side EBUS transaction sequencer.
// Takes one request (cs/func/data) at a time and runs the demand/ack/xfer handshake.
// It captures read data and returns one response pulse with status flags.
// Optional feature macro: EBUS_PARITY_EN enables odd parity generation and checking.
module ebus_master_seq #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned XFER_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    input  logic [6:0]  reqCS,
    input  logic [2:0]  reqFunc,
    input  logic [35:0] reqData,
    input  logic        abort,
    output logic        busy,
    output logic        rspValid,
    output logic [35:0] rspData,
    output logic        rspTimeout,
    output logic        rspIllegal,
    output logic        rspParErr,
    output logic [6:0]  ebusCS,
    output logic [2:0]  ebusFunc,
    output logic        ebusDemand,
    output logic        ebusReset,
    output logic        ebusParity,
    output logic [36:0] ebusDrv,
    input  logic [35:0] ebusData,
    input  logic        ebusParIn,
    input  logic        ebusAck,
    input  logic        ebusXfer
);

    localparam int unsigned MaxAx  = (ACK_TIMEOUT > XFER_TIMEOUT) ? ACK_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned MaxAll = (MaxAx > SETUP_CYCLES) ? MaxAx : SETUP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxAll + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDemand,
        StXfer,
        StRelease,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [6:0]        cs_q, cs_d;
    logic [2:0]        func_q, func_d;
    logic [35:0]       wdata_q, wdata_d;
    logic [35:0]       rdata_q, rdata_d;
    logic              timeout_q, timeout_d;
    logic              illegal_q, illegal_d;
    logic              parerr_q, parerr_d;

    logic [CntW-1:0]   cnt_inc;
    logic              is_read;
    logic              abort_hit;
    logic              rd_par_err;
    logic              driving;

    // cnt_q counts cycles already spent in the current state; cnt_inc includes this one,
    // so a limit of N allows exactly N cycles in that state.
    assign cnt_inc   = cnt_q + CntW'(1);
    assign is_read   = func_q[0];
    assign abort_hit = abort && (state_q inside {StSetup, StDemand, StXfer, StRelease});

`ifdef EBUS_PARITY_EN
    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign rd_par_err = ~(^{ebusData, ebusParIn});
`else
    logic unused_par_in;
    assign unused_par_in = ebusParIn;
    assign rd_par_err    = 1'b0;
`endif

    // State register and latched request/response fields.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cs_q      <= '0;
            func_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
            parerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
            func_q    <= func_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
            parerr_q  <= parerr_d;
        end
    end

    // Next-state logic for the handshake sequencer; abort overrides every active state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        func_d    = func_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        illegal_d = illegal_q;
        parerr_d  = parerr_q;

        if (abort_hit) begin
            state_d   = StRelease;
            timeout_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (reqValid) begin
                        cs_d      = reqCS;
                        func_d    = reqFunc;
                        wdata_d   = reqData;
                        rdata_d   = '0;
                        timeout_d = 1'b0;
                        parerr_d  = 1'b0;
                        cnt_d     = '0;
                        if (reqFunc[2:1] == 2'b11) begin
                            illegal_d = 1'b1;
                            state_d   = StDone;
                        end else begin
                            illegal_d = 1'b0;
                            state_d   = StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_inc >= CntW'(SETUP_CYCLES)) begin
                        cnt_d   = '0;
                        state_d = StDemand;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StDemand: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (ebusAck) begin
                        cnt_d   = '0;
                        state_d = StXfer;
                    end else if (cnt_inc == CntW'(ACK_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = StRelease;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StXfer: begin
                    if (ebusXfer) begin
                        if (is_read) begin
                            rdata_d  = ebusData;
                            parerr_d = rd_par_err;
                        end
                        state_d = StRelease;
                    end else if (cnt_inc == CntW'(XFER_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = StRelease;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StRelease: begin
                    if (!ebusAck && !ebusXfer) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Bus and response outputs decoded from the current state.
    assign driving    = !is_read && (state_q inside {StSetup, StDemand, StXfer});
    assign busy       = (state_q != StIdle);
    assign rspValid   = (state_q == StDone);
    assign rspData    = rdata_q;
    assign rspTimeout = timeout_q;
    assign rspIllegal = illegal_q;
    assign rspParErr  = parerr_q;
    assign ebusCS     = (state_q inside {StSetup, StDemand, StXfer, StRelease}) ? cs_q : 7'd0;
    assign ebusFunc   = (state_q inside {StSetup, StDemand, StXfer, StRelease}) ? func_q : 3'd0;
    assign ebusDemand = (state_q inside {StDemand, StXfer});
    assign ebusReset  = abort;
    assign ebusDrv    = {(driving ? wdata_q : 36'd0), driving};

`ifdef EBUS_PARITY_EN
    assign ebusParity = driving ? ~(^wdata_q) : 1'b0;
`else
    assign ebusParity = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_master_seq.sv
// Directed testbench for ebus_master_seq with default parameters.
// Each step drives inputs 1 time unit after a rising edge and checks outputs there.
module tb_ebus_master_seq;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic [6:0]  reqCS;
    logic [2:0]  reqFunc;
    logic [35:0] reqData;
    logic        abort;
    logic        busy;
    logic        rspValid;
    logic [35:0] rspData;
    logic        rspTimeout;
    logic        rspIllegal;
    logic        rspParErr;
    logic [6:0]  ebusCS;
    logic [2:0]  ebusFunc;
    logic        ebusDemand;
    logic        ebusReset;
    logic        ebusParity;
    logic [36:0] ebusDrv;
    logic [35:0] ebusData;
    logic        ebusParIn;
    logic        ebusAck;
    logic        ebusXfer;

    int tests = 0;
    int bad   = 0;

`ifdef EBUS_PARITY_EN
    localparam logic ExpParO3   = 1'b1;
    localparam logic ExpParErr  = 1'b1;
`else
    localparam logic ExpParO3   = 1'b0;
    localparam logic ExpParErr  = 1'b0;
`endif

    ebus_master_seq dut (
        .clk        (clk),
        .resetN     (resetN),
        .reqValid   (reqValid),
        .reqCS      (reqCS),
        .reqFunc    (reqFunc),
        .reqData    (reqData),
        .abort      (abort),
        .busy       (busy),
        .rspValid   (rspValid),
        .rspData    (rspData),
        .rspTimeout (rspTimeout),
        .rspIllegal (rspIllegal),
        .rspParErr  (rspParErr),
        .ebusCS     (ebusCS),
        .ebusFunc   (ebusFunc),
        .ebusDemand (ebusDemand),
        .ebusReset  (ebusReset),
        .ebusParity (ebusParity),
        .ebusDrv    (ebusDrv),
        .ebusData   (ebusData),
        .ebusParIn  (ebusParIn),
        .ebusAck    (ebusAck),
        .ebusXfer   (ebusXfer)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [6:0] cs, input logic [2:0] fn, input logic [35:0] d);
        reqValid = 1'b1;
        reqCS    = cs;
        reqFunc  = fn;
        reqData  = d;
        tick();
        reqValid = 1'b0;
    endtask

    initial begin
        resetN    = 1'b0;
        reqValid  = 1'b0;
        reqCS     = '0;
        reqFunc   = '0;
        reqData   = '0;
        abort     = 1'b0;
        ebusData  = '0;
        ebusParIn = 1'b0;
        ebusAck   = 1'b0;
        ebusXfer  = 1'b0;
        #12;
        resetN = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rspvalid", 64'(rspValid), 64'd0);
        chk("rst_drv", 64'(ebusDrv), 64'd0);
        chk("rst_cs", 64'(ebusCS), 64'd0);
        chk("rst_demand", 64'(ebusDemand), 64'd0);
        tick();

        // DATAO with delayed ack/xfer; RELEASE held while device keeps ack/xfer up.
        req(7'o14, 3'b010, 36'o123456701234);                       // T1 SETUP
        chk("wr_t1_busy", 64'(busy), 64'd1);
        chk("wr_t1_cs", 64'(ebusCS), 64'(7'o14));
        chk("wr_t1_func", 64'(ebusFunc), 64'd2);
        chk("wr_t1_drv", 64'(ebusDrv), 64'({36'o123456701234, 1'b1}));
        chk("wr_t1_par", 64'(ebusParity), 64'd0);
        chk("wr_t1_demand", 64'(ebusDemand), 64'd0);
        tick();                                                       // T2 SETUP
        chk("wr_t2_demand", 64'(ebusDemand), 64'd0);
        tick();                                                       // T3 DEMAND
        chk("wr_t3_demand", 64'(ebusDemand), 64'd1);
        tick();
        tick();                                                       // T5 DEMAND
        ebusAck = 1'b1;
        tick();                                                       // T6 XFER
        chk("wr_xfer_demand", 64'(ebusDemand), 64'd1);
        chk("wr_xfer_drv", 64'(ebusDrv), 64'({36'o123456701234, 1'b1}));
        reqValid = 1'b1;
        reqCS    = 7'o77;
        reqFunc  = 3'b011;
        tick();                                                       // T7 XFER
        reqValid = 1'b0;
        chk("wr_busy_ignore_cs", 64'(ebusCS), 64'(7'o14));
        chk("wr_busy_ignore_fn", 64'(ebusFunc), 64'd2);
        ebusXfer = 1'b1;
        tick();                                                       // T8 RELEASE
        chk("wr_rel_demand", 64'(ebusDemand), 64'd0);
        chk("wr_rel_drv", 64'(ebusDrv), 64'd0);
        chk("wr_rel_cs", 64'(ebusCS), 64'(7'o14));
        tick();                                                       // T9 still RELEASE
        chk("wr_rel_hold", 64'(rspValid), 64'd0);
        chk("wr_rel_hold_busy", 64'(busy), 64'd1);
        ebusAck  = 1'b0;
        ebusXfer = 1'b0;
        tick();                                                       // T10 DONE
        chk("wr_done_valid", 64'(rspValid), 64'd1);
        chk("wr_done_data", 64'(rspData), 64'd0);
        chk("wr_done_flags", 64'({rspTimeout, rspIllegal, rspParErr}), 64'd0);
        tick();
        chk("wr_idle_valid", 64'(rspValid), 64'd0);
        chk("wr_idle_busy", 64'(busy), 64'd0);
        chk("wr_idle_cs", 64'(ebusCS), 64'd0);

        // DATAI at minimum latency; ack and xfer together in the first DEMAND cycle.
        req(7'o20, 3'b011, 36'o555555555555);                       // T1
        chk("rd_t1_drv", 64'(ebusDrv), 64'd0);
        chk("rd_t1_cs", 64'(ebusCS), 64'(7'o20));
        tick();                                                       // T2
        tick();                                                       // T3 DEMAND
        chk("rd_t3_drv", 64'(ebusDrv), 64'd0);
        ebusAck   = 1'b1;
        ebusXfer  = 1'b1;
        ebusData  = 36'o777000111222;
        ebusParIn = 1'b0;
        tick();                                                       // T4 XFER
        chk("rd_t4_demand", 64'(ebusDemand), 64'd1);
        chk("rd_t4_valid", 64'(rspValid), 64'd0);
        tick();                                                       // T5 RELEASE
        chk("rd_t5_demand", 64'(ebusDemand), 64'd0);
        ebusAck  = 1'b0;
        ebusXfer = 1'b0;
        ebusData = '0;
        tick();                                                       // T6 DONE
        chk("rd_t6_valid", 64'(rspValid), 64'd1);
        chk("rd_t6_data", 64'(rspData), 64'(36'o777000111222));
        chk("rd_t6_parerr", 64'(rspParErr), 64'd0);
        chk("rd_t6_drv", 64'(ebusDrv), 64'd0);
        tick();

        // CONI with no ack: 64 DEMAND cycles then timeout into RELEASE.
        req(7'o01, 3'b001, 36'd0);                                   // T1
        tick();
        tick();                                                       // T3 DEMAND
        chk("to_demand_rise", 64'(ebusDemand), 64'd1);
        for (int i = 0; i < 63; i++) tick();                         // D+63
        chk("to_d63_demand", 64'(ebusDemand), 64'd1);
        chk("to_d63_flag", 64'(rspTimeout), 64'd0);
        tick();                                                       // D+64
        chk("to_d64_demand", 64'(ebusDemand), 64'd0);
        chk("to_d64_flag", 64'(rspTimeout), 64'd1);
        tick();                                                       // DONE
        chk("to_done_valid", 64'(rspValid), 64'd1);
        chk("to_done_data", 64'(rspData), 64'd0);
        tick();
        chk("to_flag_hold", 64'(rspTimeout), 64'd1);

        // Illegal function code: straight to DONE, nothing on the bus.
        req(7'o33, 3'b110, 36'd0);
        chk("ill_valid", 64'(rspValid), 64'd1);
        chk("ill_flag", 64'(rspIllegal), 64'd1);
        chk("ill_to_clr", 64'(rspTimeout), 64'd0);
        chk("ill_cs", 64'(ebusCS), 64'd0);
        chk("ill_demand", 64'(ebusDemand), 64'd0);
        tick();
        chk("ill_idle_valid", 64'(rspValid), 64'd0);
        chk("ill_hold", 64'(rspIllegal), 64'd1);

        // Abort during XFER; data 36'o3 has two ones so its odd parity bit is 1.
        req(7'o05, 3'b000, 36'o3);                                   // T1
        chk("ab_par", 64'(ebusParity), 64'(ExpParO3));
        tick();
        tick();                                                       // T3 DEMAND
        ebusAck = 1'b1;
        tick();                                                       // T4 XFER
        abort = 1'b1;
        ebusXfer = 1'b1;
        #1;
        chk("ab_reset_hi", 64'(ebusReset), 64'd1);
        chk("ab_demand_same", 64'(ebusDemand), 64'd1);
        tick();                                                       // RELEASE
        chk("ab_demand_drop", 64'(ebusDemand), 64'd0);
        chk("ab_timeout", 64'(rspTimeout), 64'd1);
        chk("ab_drv_off", 64'(ebusDrv), 64'd0);
        abort    = 1'b0;
        ebusAck  = 1'b0;
        ebusXfer = 1'b0;
        #1;
        chk("ab_reset_lo", 64'(ebusReset), 64'd0);
        tick();                                                       // DONE
        chk("ab_done_valid", 64'(rspValid), 64'd1);
        chk("ab_done_to", 64'(rspTimeout), 64'd1);
        tick();

        // Abort while idle: only ebusReset, no response.
        abort = 1'b1;
        #1;
        chk("abi_reset", 64'(ebusReset), 64'd1);
        tick();
        chk("abi_busy", 64'(busy), 64'd0);
        chk("abi_valid", 64'(rspValid), 64'd0);
        abort = 1'b0;
        tick();

        // Asynchronous reset mid-transaction clears outputs at once.
        req(7'o14, 3'b010, 36'o123456701234);
        tick();
        tick();                                                       // DEMAND
        chk("rs_pre_demand", 64'(ebusDemand), 64'd1);
        resetN = 1'b0;
        #1;
        chk("rs_demand", 64'(ebusDemand), 64'd0);
        chk("rs_drv", 64'(ebusDrv), 64'd0);
        chk("rs_cs_busy", 64'({ebusCS, busy}), 64'd0);
        #2;
        resetN = 1'b1;
        tick();

        // CONI with wrong parity on the bus; data is still returned.
        req(7'o02, 3'b001, 36'd0);
        tick();
        tick();                                                       // DEMAND
        ebusAck = 1'b1;
        tick();                                                       // XFER
        ebusXfer  = 1'b1;
        ebusData  = 36'o777000111222;
        ebusParIn = 1'b1;
        tick();                                                       // RELEASE
        ebusAck   = 1'b0;
        ebusXfer  = 1'b0;
        ebusData  = '0;
        ebusParIn = 1'b0;
        tick();                                                       // DONE
        chk("pe_valid", 64'(rspValid), 64'd1);
        chk("pe_data", 64'(rspData), 64'(36'o777000111222));
        chk("pe_flag", 64'(rspParErr), 64'(ExpParErr));
        tick();

        $display("test done: total=%0d bad=%0d", tests, bad);
        $finish;
    end

endmodule
